// File: rtl/hamming_reg_pkg.sv
// Shared types and constants for the Hamming-protected shift register sequencer.
package hamming_reg_pkg;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'b00,
        OP_SHIFT_OUT = 2'b01,
        OP_SHIFT_IN  = 2'b10,
        OP_READ      = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SHIFT,
        LOAD,
        DONE
    } state_e;

    localparam logic [1:0] MODE_SISO_R = 2'b00;
    localparam logic [1:0] MODE_SISO_L = 2'b01;
    localparam logic [1:0] MODE_PISO   = 2'b10;
    localparam logic [1:0] MODE_PIPO   = 2'b11;

endpackage

// File: rtl/hamming_fault_counter.sv
// Saturating count of corrected register faults with a synchronous clear and
// a threshold alarm.
module hamming_fault_counter #(
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] TH = CNT_W'(ALARM_TH);

    // Clear takes priority so a fault in the same cycle is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign alarm = (count >= TH);

endmodule

// File: rtl/hamming_reg_ctrl.sv
// Command sequencer for one Hamming-protected shift register: runs word-level
// ops, inserts a correction cycle before data is used and tallies faults.
module hamming_reg_ctrl #(
    parameter int WIDTH    = 4,
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out,
    input  logic             reg_fault,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count,
    output logic             alarm
);

    import hamming_reg_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state;
    state_e           state_nxt;
    op_e              op_q;
    logic [WIDTH-1:0] word_q;
    logic [CW-1:0]    bit_cnt;
    logic             accept;
    logic             last_bit;

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign cmd_ready = rst && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign last_bit  = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= OP_LOAD;
            word_q   <= '0;
            bit_cnt  <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                op_q   <= op_e'(cmd_op);
                word_q <= cmd_data;
            end
            case (state)
                PRE: begin
                    bit_cnt <= '0;
                    if (op_q == OP_READ) begin
                        rsp_data <= reg_parallel_out;
                    end
                end
                LOAD: begin
                    rsp_data <= word_q;
                end
                SHIFT: begin
                    bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    // Rotated-out bits arrive LSB first.
                    if (op_q == OP_SHIFT_OUT) begin
                        rsp_data[bit_cnt] <= reg_serial_out;
                    end else begin
                        rsp_data <= word_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        reg_enable      = 1'b0;
        reg_mode        = MODE_PIPO;
        reg_load        = 1'b0;
        reg_serial_in   = 1'b0;
        reg_parallel_in = '0;
        rsp_valid       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (op_e'(cmd_op) == OP_LOAD) ? LOAD : PRE;
                end
            end
            PRE: begin
                state_nxt = (op_q == OP_READ) ? DONE : SHIFT;
            end
            LOAD: begin
                reg_enable      = 1'b1;
                reg_load        = 1'b1;
                reg_parallel_in = word_q;
                state_nxt       = DONE;
            end
            SHIFT: begin
                reg_enable    = 1'b1;
                reg_mode      = MODE_SISO_R;
                // Feeding serial_out back in keeps the stored word intact.
                reg_serial_in = (op_q == OP_SHIFT_OUT) ? reg_serial_out : word_q[bit_cnt];
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    hamming_fault_counter #(
        .CNT_W    (CNT_W),
        .ALARM_TH (ALARM_TH)
    ) u_fault_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (!reg_enable && reg_fault),
        .clr   (err_clr),
        .count (err_count),
        .alarm (alarm)
    );

endmodule

// File: tb/tb_hamming_reg_ctrl.sv
// Bench for hamming_reg_ctrl: a behavioural shift-register model plus table
// vectors and hand-written fault, saturation and reset sequences.
module tb_hamming_reg_ctrl;

    localparam int WIDTH    = 4;
    localparam int CNT_W    = 8;
    localparam int ALARM_TH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             reg_enable;
    logic [1:0]       reg_mode;
    logic             reg_load;
    logic             reg_serial_in;
    logic [WIDTH-1:0] reg_parallel_in;
    logic             reg_serial_out;
    logic [WIDTH-1:0] reg_parallel_out;
    logic             reg_fault;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_count;
    logic             alarm;

    logic [WIDTH-1:0] model_q = '0;
    logic [WIDTH-1:0] fault_mask = '0;
    logic             stuck_fault = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] exp_rsp;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    hamming_reg_ctrl #(
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W),
        .ALARM_TH (ALARM_TH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .reg_enable       (reg_enable),
        .reg_mode         (reg_mode),
        .reg_load         (reg_load),
        .reg_serial_in    (reg_serial_in),
        .reg_parallel_in  (reg_parallel_in),
        .reg_serial_out   (reg_serial_out),
        .reg_parallel_out (reg_parallel_out),
        .reg_fault        (reg_fault),
        .err_clr          (err_clr),
        .err_count        (err_count),
        .alarm            (alarm)
    );

    // Register model: PIPO load, right shift (serial_in enters the MSB); the
    // stored word is always presented corrected, faults only raise the flag.
    always @(posedge clk) begin
        if (reg_enable && reg_mode == 2'b11 && reg_load) begin
            model_q <= reg_parallel_in;
        end else if (reg_enable && reg_mode == 2'b00) begin
            model_q <= {reg_serial_in, model_q[WIDTH-1:1]};
        end
    end

    assign reg_serial_out   = model_q[0];
    assign reg_parallel_out = model_q;
    assign reg_fault        = (|fault_mask) || stuck_fault;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one command, keeps cmd_valid high with scrambled op/data while busy,
    // and returns the response word and cycles from accept to rsp_valid.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data,
                                 output logic [3:0] rsp, output int lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        rsp       = 'x;
        lat       = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cmd_op   = ~op;
            cmd_data = ~data;
            checkOutput("busy_ready", {31'b0, cmd_ready}, 32'd0);
            if (rsp_valid) begin
                rsp = rsp_data;
                break;
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rsp_pulse_end", {31'b0, rsp_valid}, 32'd0);
        checkOutput("ready_after", {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic runCmd(input string name, input logic [1:0] op, input logic [3:0] data,
                          input logic [3:0] exp_rsp, input int exp_lat);
        logic [3:0] rsp;
        int         lat;
        applyStimulus(op, data, rsp, lat);
        checkOutput({name, "_rsp"}, {28'b0, rsp}, {28'b0, exp_rsp});
        checkOutput({name, "_lat"}, lat, exp_lat);
    endtask

    task automatic injectFault(input int bit_idx, input logic [7:0] exp_after);
        @(negedge clk);
        fault_mask = 4'b0001 << bit_idx;
        @(posedge clk);
        #1 fault_mask = '0;
        @(negedge clk);
        checkOutput("err_count_inject", {24'b0, err_count}, {24'b0, exp_after});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        checkOutput({tag, "_rsp_data"}, {28'b0, rsp_data}, 32'd0);
        checkOutput({tag, "_enable"}, {31'b0, reg_enable}, 32'd0);
        checkOutput({tag, "_mode"}, {30'b0, reg_mode}, 32'd3);
        checkOutput({tag, "_load"}, {31'b0, reg_load}, 32'd0);
        checkOutput({tag, "_sin"}, {31'b0, reg_serial_in}, 32'd0);
        checkOutput({tag, "_pin"}, {28'b0, reg_parallel_in}, 32'd0);
        checkOutput({tag, "_err"}, {24'b0, err_count}, 32'd0);
        checkOutput({tag, "_alarm"}, {31'b0, alarm}, 32'd0);
        checkOutput({tag, "_ready"}, {31'b0, cmd_ready}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"load_a",     2'b00, 4'hA, 4'hA, 2};
        vecs[1] = '{"read_a",     2'b11, 4'h0, 4'hA, 2};
        vecs[2] = '{"load_5",     2'b00, 4'h5, 4'h5, 2};
        vecs[3] = '{"sout_5",     2'b01, 4'h0, 4'h5, 6};
        vecs[4] = '{"read_5",     2'b11, 4'hF, 4'h5, 2};
        vecs[5] = '{"load_9",     2'b00, 4'h9, 4'h9, 2};
        vecs[6] = '{"sin_3",      2'b10, 4'h3, 4'h3, 6};
        vecs[7] = '{"sout_3",     2'b01, 4'h0, 4'h3, 6};

        #3;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_release", {31'b0, cmd_ready}, 32'd1);
        checkOutput("mode_idle", {30'b0, reg_mode}, 32'd3);

        for (int i = 0; i < 8; i++) begin
            runCmd(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].exp_rsp, vecs[i].exp_lat);
        end
        checkOutput("err_no_faults", {24'b0, err_count}, 32'd0);

        // Single-bit fault in IDLE is counted once and corrected before use.
        runCmd("load_6", 2'b00, 4'h6, 4'h6, 2);
        injectFault(2, 8'd1);
        runCmd("sout_6", 2'b01, 4'h0, 4'h6, 6);
        injectFault(0, 8'd2);
        checkOutput("alarm_below", {31'b0, alarm}, 32'd0);
        injectFault(3, 8'd3);
        checkOutput("alarm_at_th", {31'b0, alarm}, 32'd1);

        // Saturation, then clear winning over a simultaneous fault.
        @(negedge clk);
        stuck_fault = 1'b1;
        repeat (260) @(posedge clk);
        @(negedge clk);
        checkOutput("err_saturate", {24'b0, err_count}, 32'd255);
        checkOutput("alarm_sat", {31'b0, alarm}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        checkOutput("err_clr_wins", {24'b0, err_count}, 32'd0);
        checkOutput("alarm_cleared", {31'b0, alarm}, 32'd0);
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_resume", {24'b0, err_count}, 32'd1);
        stuck_fault = 1'b0;

        // Reset in the middle of a SHIFT_OUT.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("mid_shift_mode", {30'b0, reg_mode}, 32'd0);
        rst = 1'b0;
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_rsp_after_reset", {31'b0, rsp_valid}, 32'd0);
            checkOutput("ready_after_reset", {31'b0, cmd_ready}, 32'd1);
        end

        runCmd("sin_c", 2'b10, 4'hC, 4'hC, 6);
        runCmd("read_c", 2'b11, 4'h0, 4'hC, 2);
        checkOutput("err_end", {24'b0, err_count}, 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
